// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and per-bit operand/logic functions for the CLA ALU
package alu_pkg;
  localparam int SLICE_W = 4;
  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;
  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_ONES = 4'b0011;
  localparam logic [3:0] SEL_XOR = 4'b0110;
  // Arithmetic adder terms are bitwise in A and B, returned as {x, y}
  function automatic logic [1:0] xy_bit(input logic a, input logic b, input logic [3:0] sel);
    case (sel)
      4'h0: return {a, 1'b0};
      4'h1: return {a | b, 1'b0};
      4'h2: return {a | ~b, 1'b0};
      4'h3: return {1'b1, 1'b0};
      4'h4: return {a, a & ~b};
      4'h5: return {a | b, a & ~b};
      4'h6: return {a, ~b};
      4'h7: return {a & ~b, 1'b1};
      4'h8: return {a, a & b};
      4'h9: return {a, b};
      4'hA: return {a | ~b, a & b};
      4'hB: return {a & b, 1'b1};
      4'hC: return {a, a};
      4'hD: return {a | b, a};
      4'hE: return {a | ~b, a};
      default: return {a, 1'b1};
    endcase
  endfunction
  function automatic logic lgc_bit(input logic a, input logic b, input logic [3:0] sel);
    case (sel)
      4'h0: return ~a;
      4'h1: return ~(a | b);
      4'h2: return ~a & b;
      4'h3: return 1'b0;
      4'h4: return ~(a & b);
      4'h5: return ~b;
      4'h6: return a ^ b;
      4'h7: return a & ~b;
      4'h8: return ~a | b;
      4'h9: return ~(a ^ b);
      4'hA: return b;
      4'hB: return a & b;
      4'hC: return 1'b1;
      4'hD: return a | ~b;
      4'hE: return a | b;
      default: return a;
    endcase
  endfunction
endpackage

// File: rtl/cla_slice4.sv
// cla_slice4: 4-bit slice producing P/G, both conditional sums and the logic result
module cla_slice4
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               mode_i,
  input  logic [3:0]         sel_i,
  output logic               p_o,
  output logic               g_o,
  output logic [SLICE_W-1:0] sum0_o,
  output logic [SLICE_W-1:0] sum1_o,
  output logic [SLICE_W-1:0] lgc_o
);
  logic [SLICE_W-1:0] x, y;
  logic cout;
  always_comb begin
    x = '0;
    y = '0;
    lgc_o = '0;
    for (int k = 0; k < SLICE_W; k++) begin
      {x[k], y[k]} = xy_bit(a_i[k], b_i[k], sel_i);
      lgc_o[k] = lgc_bit(a_i[k], b_i[k], sel_i);
    end
    {cout, sum0_o} = {1'b0, x} + {1'b0, y};
    sum1_o = x + y + 4'd1;
    // P/G are forced low in logic mode so no carry can ever reach the result
    p_o = ~mode_i & (&(x ^ y));
    g_o = ~mode_i & cout;
  end
endmodule

// File: rtl/pipelined_cla_alu.sv
// pipelined_cla_alu: two-stage 74181-style ALU with slice carry-select and valid/ready handshake
module pipelined_cla_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mode_i,
  input  logic [3:0]       sel_i,
  input  logic             carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] f_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             gp_o,
  output logic             gg_o
);
  localparam int NS = WIDTH / SLICE_W;
  if (WIDTH % SLICE_W != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end
  logic [NS-1:0] p_w, g_w;
  logic [NS-1:0][SLICE_W-1:0] s0_w, s1_w, lg_w;
  logic [1:0] xy_msb;
  for (genvar i = 0; i < NS; i++) begin : g_sl
    cla_slice4 u_slice (
      .a_i   (a_i[i*SLICE_W +: SLICE_W]),
      .b_i   (b_i[i*SLICE_W +: SLICE_W]),
      .mode_i(mode_i),
      .sel_i (sel_i),
      .p_o   (p_w[i]),
      .g_o   (g_w[i]),
      .sum0_o(s0_w[i]),
      .sum1_o(s1_w[i]),
      .lgc_o (lg_w[i])
    );
  end
  // MSB propagate is kept so stage 2 can recover the carry into the sign bit
  assign xy_msb = xy_bit(a_i[WIDTH-1], b_i[WIDTH-1], sel_i);
  logic s1_valid_q, s1_valid_d, mode_q, mode_d, cin_q, cin_d, pm_q, pm_d;
  logic [NS-1:0] p_q, p_d, g_q, g_d;
  logic [NS-1:0][SLICE_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic out_valid_q, out_valid_d, carry_q, carry_d, zero_q, zero_d;
  logic ovf_q, ovf_d, gp_q, gp_d, gg_q, gg_d;
  logic [WIDTH-1:0] f_q, f_d, f_n;
  logic [NS:0] c;
  logic gacc, s2_load, acc, ld2;
  assign s2_load = ~out_valid_q | out_ready_i;
  assign in_ready_o = ~s1_valid_q | s2_load;
  assign acc = in_valid_i & in_ready_o;
  assign ld2 = s2_load & s1_valid_q;
  always_comb begin
    s1_valid_d = acc | (s1_valid_q & ~s2_load);
    mode_d = acc ? mode_i : mode_q;
    cin_d = acc ? carry_i & ~mode_i : cin_q;
    pm_d = acc ? ~mode_i & (xy_msb[1] ^ xy_msb[0]) : pm_q;
    p_d = acc ? p_w : p_q;
    g_d = acc ? g_w : g_q;
    lo_d = acc ? (mode_i ? lg_w : s0_w) : lo_q;
    hi_d = acc ? s1_w : hi_q;
  end
  always_comb begin
    c = '0;
    c[0] = cin_q;
    gacc = 1'b0;
    f_n = '0;
    for (int k = 0; k < NS; k++) begin
      c[k+1] = g_q[k] | (p_q[k] & c[k]);
      gacc = g_q[k] | (p_q[k] & gacc);
      f_n[k*SLICE_W +: SLICE_W] = c[k] ? hi_q[k] : lo_q[k];
    end
    out_valid_d = s2_load ? s1_valid_q : out_valid_q;
    f_d = ld2 ? f_n : f_q;
    carry_d = ld2 ? c[NS] : carry_q;
    zero_d = ld2 ? ~|f_n : zero_q;
    ovf_d = ld2 ? ~mode_q & (c[NS] ^ f_n[WIDTH-1] ^ pm_q) : ovf_q;
    gp_d = ld2 ? &p_q : gp_q;
    gg_d = ld2 ? gacc : gg_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      mode_q <= 1'b0;
      cin_q <= 1'b0;
      pm_q <= 1'b0;
      p_q <= '0;
      g_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      out_valid_q <= 1'b0;
      f_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      gp_q <= 1'b0;
      gg_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      mode_q <= mode_d;
      cin_q <= cin_d;
      pm_q <= pm_d;
      p_q <= p_d;
      g_q <= g_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      out_valid_q <= out_valid_d;
      f_q <= f_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      gp_q <= gp_d;
      gg_q <= gg_d;
    end
  end
  assign out_valid_o = out_valid_q;
  assign f_o = f_q;
  assign carry_o = carry_q;
  assign zero_o = zero_q;
  assign ovf_o = ovf_q;
  assign gp_o = gp_q;
  assign gg_o = gg_q;
endmodule

// File: tb/tb_pipelined_cla_alu.sv
// tb_pipelined_cla_alu: scoreboard bench for the pipelined CLA ALU
module tb_pipelined_cla_alu;
  import alu_pkg::*;
  localparam int W = 16;
  logic clk_i = 1'b0, rst_n_i = 1'b0, in_valid_i = 1'b0, mode_i = 1'b0, carry_i = 1'b0;
  logic out_ready_i = 1'b1, in_ready_o, out_valid_o, carry_o, zero_o, ovf_o, gp_o, gg_o;
  logic [W-1:0] a_i = '0, b_i = '0, f_o;
  logic [3:0] sel_i = '0;
  logic [W+4:0] q[$];
  int n_cmp = 0, n_err = 0;
  always #5 clk_i = ~clk_i;
  pipelined_cla_alu #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .mode_i(mode_i), .sel_i(sel_i), .carry_i(carry_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .f_o(f_o), .carry_o(carry_o),
    .zero_o(zero_o), .ovf_o(ovf_o), .gp_o(gp_o), .gg_o(gg_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [W+4:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic m, input logic [3:0] s, input logic c);
    logic [W-1:0] x, y, f;
    logic [W:0] sum, raw;
    int sv;
    logic ov;
    if (m) begin
      case (s)
        4'h0: f = ~a;         4'h1: f = ~(a | b);   4'h2: f = ~a & b;     4'h3: f = '0;
        4'h4: f = ~(a & b);   4'h5: f = ~b;         4'h6: f = a ^ b;      4'h7: f = a & ~b;
        4'h8: f = ~a | b;     4'h9: f = ~(a ^ b);   4'hA: f = b;          4'hB: f = a & b;
        4'hC: f = '1;         4'hD: f = a | ~b;     4'hE: f = a | b;      default: f = a;
      endcase
      return {f, 1'b0, f == '0, 3'b000};
    end
    case (s)
      4'h0: begin x = a; y = '0; end
      4'h1: begin x = a | b; y = '0; end
      4'h2: begin x = a | ~b; y = '0; end
      4'h3: begin x = '1; y = '0; end
      4'h4: begin x = a; y = a & ~b; end
      4'h5: begin x = a | b; y = a & ~b; end
      4'h6: begin x = a; y = ~b; end
      4'h7: begin x = a & ~b; y = '1; end
      4'h8: begin x = a; y = a & b; end
      4'h9: begin x = a; y = b; end
      4'hA: begin x = a | ~b; y = a & b; end
      4'hB: begin x = a & b; y = '1; end
      4'hC: begin x = a; y = a; end
      4'hD: begin x = a | b; y = a; end
      4'hE: begin x = a | ~b; y = a; end
      default: begin x = a; y = '1; end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    raw = {1'b0, x} + {1'b0, y};
    sv = int'($signed(x)) + int'($signed(y)) + int'(c);
    ov = (sv > 32767) || (sv < -32768);
    return {sum[W-1:0], sum[W], sum[W-1:0] == '0, ov, &(x ^ y), raw[W]};
  endfunction
  task automatic cyc(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                     input logic [3:0] s, input logic c, input logic ordy, input logic [W+4:0] e,
                     output logic acc);
    @(negedge clk_i);
    in_valid_i = iv; a_i = a; b_i = b; mode_i = m; sel_i = s; carry_i = c; out_ready_i = ordy;
    #1;
    chk("in_ready", in_ready_o, !(q.size() == 2 && !out_ready_i));
    if (out_valid_o && out_ready_i) begin
      if (q.size() == 0) chk("spurious", out_valid_o, 0);
      else chk("result", {f_o, carry_o, zero_o, ovf_o, gp_o, gg_o}, q.pop_front());
    end
    acc = in_valid_i && in_ready_o;
    if (acc) q.push_back(e);
  endtask
  task automatic idle(input logic ordy);
    logic acc;
    cyc(1'b0, '0, '0, 1'b0, 4'h0, 1'b0, ordy, '0, acc);
  endtask
  task automatic lat_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [3:0] s, input logic c, input logic [W+4:0] e);
    logic acc;
    cyc(1'b1, a, b, m, s, c, 1'b1, e, acc);
    chk({tag, "_acc"}, acc, 1);
    idle(1'b1);
    chk({tag, "_lat1"}, out_valid_o, 0);
    idle(1'b1);
    chk({tag, "_lat2"}, out_valid_o, 1);
  endtask
  task automatic drain();
    for (int t = 0; t < 10 && q.size() > 0; t++) idle(1'b1);
    chk("drain", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic acc, m, c;
    logic [W-1:0] a, b;
    logic [3:0] s;
    int sent;
    #12;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_outs", {f_o, carry_o, zero_o, ovf_o, gp_o, gg_o}, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("rst_ready", in_ready_o, 1);
    lat_op("add", 16'h1234, 16'h0FFF, MODE_ARITH, SEL_ADD, 1'b0, {16'h2233, 5'b00000});
    lat_op("add_wrap", 16'hFFFF, 16'h0001, MODE_ARITH, SEL_ADD, 1'b0, {16'h0000, 5'b11001});
    lat_op("sub_ovf", 16'h8000, 16'h0001, MODE_ARITH, SEL_SUB, 1'b1, {16'h7FFF, 5'b10101});
    lat_op("ones", 16'h8000, 16'h0001, MODE_ARITH, SEL_ONES, 1'b0, {16'hFFFF, 5'b00010});
    lat_op("xor", 16'hF0F0, 16'hFF00, MODE_LOGIC, SEL_XOR, 1'b1, {16'h0FF0, 5'b00000});
    for (int i = 0; i < 32; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      c = 1'($urandom_range(0, 1));
      cyc(1'b1, a, b, i[4], i[3:0], c, 1'b1, model(a, b, i[4], i[3:0], c), acc);
      chk("sweep_acc", acc, 1);
    end
    drain();
    sent = 0;
    a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
    m = 1'($urandom_range(0, 1)); s = 4'($urandom_range(0, 15)); c = 1'($urandom_range(0, 1));
    for (int t = 0; t < 40 && sent < 8; t++) begin
      cyc(1'b1, a, b, m, s, c, (t % 2) == 0, model(a, b, m, s, c), acc);
      if (acc) begin
        sent++;
        a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
        m = 1'($urandom_range(0, 1)); s = 4'($urandom_range(0, 15)); c = 1'($urandom_range(0, 1));
      end
    end
    chk("stream_sent", sent, 8);
    drain();
    cyc(1'b1, 16'h0101, 16'h0202, MODE_ARITH, SEL_ADD, 1'b0, 1'b0, {16'h0303, 5'b00000}, acc);
    cyc(1'b1, 16'h1111, 16'h2222, MODE_ARITH, SEL_ADD, 1'b0, 1'b0, {16'h3333, 5'b00000}, acc);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid_o, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_outs", {f_o, carry_o, zero_o, ovf_o, gp_o, gg_o}, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    q.delete();
    #1;
    chk("post_rst_ready", in_ready_o, 1);
    for (int t = 0; t < 6; t++) idle(1'b1);
    lat_op("post_rst", 16'h00FF, 16'h0001, MODE_ARITH, SEL_ADD, 1'b1, {16'h0101, 5'b00000});
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
